aes_key_expand_serial: RTL and testbench
========================================

Name: aes_key_expand_serial

Overview:
- Byte-serial, on-the-fly AES-128 key schedule; the stage directly upstream of the round-key XOR stage.
- Loads a 16-byte cipher key. On request, streams one round key (rounds 0..10) one byte per cycle on key_out. key_out drives the XOR stage's 8-bit key input in lockstep with the state byte.
- Keeps a copy of the cipher key so encryption can restart without reloading.

Parameters:
- NUM_ROUNDS, 10, last round index emitted; fixed for AES-128, values other than 10 unsupported.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  load_byte carries a cipher-key byte this cycle
- load_byte  in  8  cipher-key byte, byte 0 (FIPS-197 order) first
- next_req  in  1  request emission of the next round key
- restart  in  1  rewind schedule to round 0 using the stored cipher key
- key_out  out  8  round-key byte
- key_valid  out  1  key_out valid this cycle
- key_last  out  1  high with byte 15 of each round key
- round  out  4  index of the round key being or last emitted
- ready  out  1  idle with valid key, next_req will be accepted
- done  out  1  round NUM_ROUNDS fully emitted

Behaviour:
- Reset (async, rst_n low): all outputs 0, state NOKEY, byte counter 0, round 0, key registers 0.
- States:
  - NOKEY: no key yet.
  - LOAD: collecting bytes.
  - READY: key available.
  - EMIT: streaming 16 bytes.
  - DONE: schedule exhausted.
- Loading:
  - load_valid in NOKEY, READY or DONE enters LOAD, stores the byte at index 0 and sets round=0.
  - In LOAD, each load_valid stores the next index; gaps without load_valid are allowed.
  - The 16th byte moves to READY next cycle.
  - load_valid during EMIT is ignored.
  - A load started in READY or DONE discards the old key.
- Emission:
  - next_req sampled high in READY at edge t gives key_valid high on cycles t+1..t+16, bytes 0..15 in order. key_last is high at t+16. Outputs are registered.
  - Round 0 emits the cipher key unchanged.
  - Round n>0 emits w[4n..4n+3], computed byte-serially from the round n-1 key:
    - bytes 0..3 = prev[0..3] ^ Sbox(prev[13],prev[14],prev[15],prev[12]) ^ rcon(n) on byte 0 only
    - byte j≥4 = prev[j] ^ new[j-4]
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - S-box is an internal combinational lookup, single instance shared across bytes 0..3.
  - round updates to the emitted index on the first byte's cycle.
- After the 16th byte:
  - If round<NUM_ROUNDS, return to READY.
  - Otherwise go to DONE with done=1 and ready=0; next_req in DONE is ignored.
  - next_req held high gives back-to-back rounds separated by exactly one idle cycle (READY re-sampled).
- next_req outside READY is ignored and not queued.
- restart:
  - In READY, EMIT or DONE, the next cycle has round=0, key_valid=0 and state READY, and the working key is reloaded from the cipher copy.
  - restart aborts an in-progress emission mid-stream; no further bytes of that round appear.
  - restart in NOKEY or LOAD is ignored.
  - restart and next_req in the same cycle: restart wins, next_req is dropped.
- ready = (state==READY). key_valid=0 in all states except EMIT.
- Reset mid-emission: key_valid drops immediately (async). The stored key is lost and a reload is required.

Test Plan:
- Load key 2b7e151628aed2a6abf7158809cf4f3c with 3 gap cycles mid-load, then next_req → round 0 bytes 2b,7e,…,3c on 16 consecutive cycles, key_last on 3c, round=0.
- Continue next_req ×10 → round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; then done=1, ready=0, and a further next_req produces no key_valid.
- Hold next_req high continuously from READY → exactly one idle cycle between each 16-byte burst, 11 bursts total.
- restart asserted after byte 5 of round 3 → key_valid low next cycle, no byte 6; next next_req emits round 0 (2b7e…3c) with round=0.
- restart and next_req together in READY at round 4 → no emission, round=0, ready=1.
- rst_n pulsed low during round 2 emission → key_valid, key_out and round go to 0 asynchronously; next_req is ignored until a full 16-byte reload completes.

Source files
------------

// File: rtl/aes_key_expand_serial.sv
// Byte-serial AES-128 key schedule feeding the round-key XOR stage.
// Keeps the cipher key so the schedule can be rewound without a reload.
module aes_key_expand_serial #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_byte,
    input  logic       next_req,
    input  logic       restart,
    output logic [7:0] key_out,
    output logic       key_valid,
    output logic       key_last,
    output logic [3:0] round,
    output logic       ready,
    output logic       done
);

    typedef enum logic [2:0] {
        NOKEY,
        LOAD,
        READY,
        EMIT,
        DONE
    } state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // entry x sits at bit 2047-8x, which is {~x, 3'b111}
        sbox = SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        unique case (n)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [7:0] work   [16];
    logic [7:0] cipher [16];
    logic [3:0] lidx;
    logic [3:0] idx;
    logic [3:0] nrnd;

    logic       do_restart;
    logic       do_lstart;
    logic       do_lnext;
    logic       do_start;
    logic       do_emit;
    logic       do_finish;

    logic [7:0] rot;
    logic [7:0] mix;
    logic [7:0] nb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= NOKEY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_restart = 1'b0;
        do_lstart  = 1'b0;
        do_lnext   = 1'b0;
        do_start   = 1'b0;
        do_emit    = 1'b0;
        do_finish  = 1'b0;
        unique case (state)
            NOKEY: begin
                if (load_valid) begin
                    do_lstart = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    do_lnext = 1'b1;
                    if (lidx == 4'd15) state_nxt = READY;
                end
            end
            READY: begin
                if (restart) begin
                    do_restart = 1'b1;
                end else if (load_valid) begin
                    do_lstart = 1'b1;
                    state_nxt = LOAD;
                end else if (next_req) begin
                    do_start  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (restart) begin
                    do_restart = 1'b1;
                    state_nxt  = READY;
                end else if (key_last) begin
                    do_finish = 1'b1;
                    state_nxt = (round == NUM_ROUNDS[3:0]) ? DONE : READY;
                end else begin
                    do_emit = 1'b1;
                end
            end
            DONE: begin
                if (restart) begin
                    do_restart = 1'b1;
                    state_nxt  = READY;
                end else if (load_valid) begin
                    do_lstart = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = NOKEY;
        endcase
    end

    // Working key is updated in place: bytes 12..15 of the previous
    // round survive until after bytes 0..3 have consumed them.
    always_comb begin
        rot = work[{2'b11, idx[1:0] + 2'd1}];
        if (idx < 4'd4) begin
            mix = sbox(rot);
            if (idx == 4'd0) mix = mix ^ rcon(nrnd);
        end else begin
            mix = work[idx - 4'd4];
        end
        nb = (nrnd == 4'd0) ? work[idx] : (work[idx] ^ mix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                work[i]   <= 8'h00;
                cipher[i] <= 8'h00;
            end
            lidx      <= 4'd0;
            idx       <= 4'd0;
            nrnd      <= 4'd0;
            round     <= 4'd0;
            key_out   <= 8'h00;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
        end else if (do_restart) begin
            for (int i = 0; i < 16; i++) work[i] <= cipher[i];
            idx       <= 4'd0;
            nrnd      <= 4'd0;
            round     <= 4'd0;
            key_out   <= 8'h00;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
        end else if (do_lstart) begin
            cipher[0] <= load_byte;
            work[0]   <= load_byte;
            lidx      <= 4'd1;
            idx       <= 4'd0;
            nrnd      <= 4'd0;
            round     <= 4'd0;
        end else if (do_lnext) begin
            cipher[lidx] <= load_byte;
            work[lidx]   <= load_byte;
            lidx         <= lidx + 4'd1;
        end else if (do_start || do_emit) begin
            work[idx] <= nb;
            key_out   <= nb;
            key_valid <= 1'b1;
            key_last  <= (idx == 4'd15);
            idx       <= idx + 4'd1;
            if (do_start) round <= nrnd;
        end else if (do_finish) begin
            key_out   <= 8'h00;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            nrnd      <= nrnd + 4'd1;
        end
    end

    assign ready = (state == READY);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_aes_key_expand_serial.sv
// Directed bench for the byte-serial AES-128 key schedule.
// Expected round keys are the published FIPS-197 example values.
module tb_aes_key_expand_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_byte = 8'h00;
    logic       next_req = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] key_out;
    logic       key_valid;
    logic       key_last;
    logic [3:0] round;
    logic       ready;
    logic       done;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] K2_R0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    aes_key_expand_serial #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .next_req   (next_req),
        .restart    (restart),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .key_last   (key_last),
        .round      (round),
        .ready      (ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input int gap_after, input int ngap);
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_byte  = k[127 - 8 * i -: 8];
            tick();
            if (i == gap_after) begin
                load_valid = 1'b0;
                repeat (ngap) tick();
            end
        end
        load_valid = 1'b0;
    endtask

    // Gathers 16 cycles of output after a request; comparisons are left to callers.
    task automatic collect(output logic [127:0] d, output int nv,
                           output int lp, output logic [3:0] rnd);
        d   = '0;
        nv  = 0;
        lp  = -1;
        rnd = 4'hf;
        for (int i = 0; i < 16; i++) begin
            if (key_valid) begin
                nv++;
                d = {d[119:0], key_out};
                if (key_last) lp = i;
            end
            if (i == 0) rnd = round;
            tick();
        end
    endtask

    task automatic request(output logic [127:0] d, output int nv,
                           output int lp, output logic [3:0] rnd);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        collect(d, nv, lp, rnd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({key_out, key_valid, key_last, round, ready, done} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {key_out, key_valid, key_last, round, ready, done});
        end
        #20;
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL nokey_ready: got %b want 0", ready);
        end
    endtask

    task automatic test_load_round0();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        load_key(RK[0], 7, 3);
        checks++;
        if (ready !== 1'b1 || round !== 4'd0) begin
            errors++;
            $display("FAIL load_ready: got ready=%b round=%0d want 1/0", ready, round);
        end
        request(d, nv, lp, rnd);
        checks++;
        if (d !== RK[0] || rnd !== 4'd0) begin
            errors++;
            $display("FAIL round0_key: got %h r%0d want %h r0", d, rnd, RK[0]);
        end
        checks++;
        if (nv != 16 || lp != 15) begin
            errors++;
            $display("FAIL round0_framing: got valid=%0d last@%0d want 16/15", nv, lp);
        end
        checks++;
        if (key_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL round0_idle: got valid=%b ready=%b want 0/1", key_valid, ready);
        end
    endtask

    task automatic test_all_rounds();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        for (int n = 1; n <= 10; n++) begin
            request(d, nv, lp, rnd);
            checks++;
            if (d !== RK[n] || rnd !== 4'(n) || nv != 16 || lp != 15) begin
                errors++;
                $display("FAIL round%0d_key: got %h r%0d v%0d l%0d want %h r%0d v16 l15",
                         n, d, rnd, nv, lp, RK[n], n);
            end
        end
        checks++;
        if (done !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL done_flags: got done=%b ready=%b want 1/0", done, ready);
        end
        request(d, nv, lp, rnd);
        checks++;
        if (nv != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_req: got valid=%0d done=%b want 0/1", nv, done);
        end
    endtask

    task automatic test_back_to_back();
        int bursts = 0;
        int run = 0;
        int gap = 0;
        int bad = 0;
        logic prev = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (round !== 4'd0 || ready !== 1'b1 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done: got r%0d ready=%b valid=%b want 0/1/0",
                     round, ready, key_valid);
        end
        next_req = 1'b1;
        tick();
        for (int c = 0; c < 200; c++) begin
            if (key_valid) begin
                if (!prev && bursts > 0 && gap != 1) bad++;
                run++;
            end else begin
                if (prev) begin
                    bursts++;
                    if (run != 16) bad++;
                    run = 0;
                    gap = 0;
                end
                gap++;
            end
            prev = key_valid;
            tick();
        end
        next_req = 1'b0;
        checks++;
        if (bursts != 11 || bad != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: got bursts=%0d bad=%0d done=%b want 11/0/1",
                     bursts, bad, done);
        end
    endtask

    task automatic test_restart_mid();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        int extra = 0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int n = 0; n < 3; n++) request(d, nv, lp, rnd);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        repeat (5) tick();
        checks++;
        if (key_out !== 8'h16 || key_valid !== 1'b1 || round !== 4'd3) begin
            errors++;
            $display("FAIL r3_byte5: got %h v%b r%0d want 16 v1 r3", key_out, key_valid, round);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || round !== 4'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_abort: got v%b r%0d ready=%b want 0/0/1",
                     key_valid, round, ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (key_valid) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL restart_no_tail: got %0d stray bytes want 0", extra);
        end
        request(d, nv, lp, rnd);
        checks++;
        if (d !== RK[0] || rnd !== 4'd0 || nv != 16) begin
            errors++;
            $display("FAIL restart_round0: got %h r%0d v%0d want %h r0 v16", d, rnd, nv, RK[0]);
        end
    endtask

    task automatic test_restart_with_next();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        for (int n = 1; n <= 4; n++) request(d, nv, lp, rnd);
        checks++;
        if (round !== 4'd4 || d !== RK[4]) begin
            errors++;
            $display("FAIL pre_round4: got r%0d %h want r4 %h", round, d, RK[4]);
        end
        restart  = 1'b1;
        next_req = 1'b1;
        tick();
        restart  = 1'b0;
        next_req = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || round !== 4'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_wins: got v%b r%0d ready=%b want 0/0/1",
                     key_valid, round, ready);
        end
        tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL dropped_req: got v%b want 0", key_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        int stray = 0;
        request(d, nv, lp, rnd);
        request(d, nv, lp, rnd);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_valid !== 1'b0 || key_out !== 8'h00 || round !== 4'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v%b %h r%0d ready=%b want 0/00/0/0",
                     key_valid, key_out, round, ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        next_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (key_valid) stray++;
        end
        load_key(RK[0], 7, 2);
        next_req = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL req_without_key: got %0d bytes want 0", stray);
        end
        tick();
        request(d, nv, lp, rnd);
        checks++;
        if (d !== RK[0] || rnd !== 4'd0 || nv != 16) begin
            errors++;
            $display("FAIL reload_round0: got %h r%0d v%0d want %h", d, rnd, nv, RK[0]);
        end
    endtask

    task automatic test_reload_in_ready();
        logic [127:0] d;
        int nv, lp;
        logic [3:0] rnd;
        load_key(K2_R0, 16, 0);
        checks++;
        if (ready !== 1'b1 || round !== 4'd0) begin
            errors++;
            $display("FAIL reload_ready: got ready=%b r%0d want 1/0", ready, round);
        end
        request(d, nv, lp, rnd);
        checks++;
        if (d !== K2_R0) begin
            errors++;
            $display("FAIL key2_round0: got %h want %h", d, K2_R0);
        end
        request(d, nv, lp, rnd);
        checks++;
        if (d !== K2_R1 || rnd !== 4'd1) begin
            errors++;
            $display("FAIL key2_round1: got %h r%0d want %h r1", d, rnd, K2_R1);
        end
    endtask

    initial begin
        test_reset();
        test_load_round0();
        test_all_rounds();
        test_back_to_back();
        test_restart_mid();
        test_restart_with_next();
        test_async_reset();
        test_reload_in_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
